// File: rtl/noc_pkg.sv
// Shared NoC router constants: default flit width and the reader's output buffer depth.
package noc_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int OUT_BUF_DEPTH  = 2;

    typedef logic [DEF_DATA_WIDTH-1:0] flit_t;

endpackage

// File: rtl/fifo_stream_reader.sv
// Drains an input FIFO (registered dout) into a valid/ready stream: read-to-out_valid is 2 cycles.
// Backpressure: issues reads only while the 2-entry buffer can absorb them; holds head stable while stalled.
module fifo_stream_reader
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_dout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [COUNT_WIDTH-1:0] xfer_count
);

    localparam logic [2:0] LP_DEPTH = 3'(OUT_BUF_DEPTH);

    logic [1:0]             r_occ;
    logic                   r_inflight;
    logic                   r_valid;
    logic [DATA_WIDTH-1:0]  r_buf0;
    logic [DATA_WIDTH-1:0]  r_buf1;
    logic [COUNT_WIDTH-1:0] r_xfer_count;

    logic       w_deq;
    logic       w_enq;
    logic       w_rd_acc;
    logic [2:0] w_level;
    logic [1:0] w_occ_nxt;
    logic       w_wr_buf0;
    logic       w_wr_buf1;

    assign w_deq = r_valid & out_ready;
    assign w_enq = r_inflight;

    // Slots committed after this cycle's dequeue; a new read must land in a free slot.
    assign w_level    = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_deq};
    assign fifo_rd_en = ~rst & ~fifo_empty & (w_level < LP_DEPTH);
    assign w_rd_acc   = fifo_rd_en & ~fifo_empty;

    assign w_wr_buf0 = w_enq & ((~w_deq & (r_occ == 2'd0)) | (w_deq & (r_occ == 2'd1)));
    assign w_wr_buf1 = w_enq & ((~w_deq & (r_occ == 2'd1)) | (w_deq & (r_occ == 2'd2)));

    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_deq, w_enq})
            2'b10:   w_occ_nxt = r_occ - 2'd1;
            2'b01:   w_occ_nxt = r_occ + 2'd1;
            default: w_occ_nxt = r_occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ        <= 2'd0;
            r_inflight   <= 1'b0;
            r_valid      <= 1'b0;
            r_buf0       <= '0;
            r_buf1       <= '0;
            r_xfer_count <= '0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_inflight <= w_rd_acc;
            r_valid    <= (w_occ_nxt != 2'd0);
            if (w_wr_buf0) begin
                r_buf0 <= fifo_dout;
            end else if (w_deq) begin
                r_buf0 <= r_buf1;
            end
            if (w_wr_buf1) begin
                r_buf1 <= fifo_dout;
            end
            r_xfer_count <= r_xfer_count + {{(COUNT_WIDTH-1){1'b0}}, w_deq};
        end
    end

    assign out_valid  = r_valid;
    assign out_data   = r_buf0;
    assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: queue-based FIFO environment plus a flit-age model.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic        out_ready = 1'b0;
    logic [31:0] fifo_dout = '0;

    wire         fifo_rd_en;
    wire         out_valid;
    wire [31:0]  out_data;
    wire [31:0]  xfer_count;
    wire         w_rd2;
    wire         w_v2;
    wire [31:0]  w_d2;
    wire [3:0]   w_cnt2;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(32), .COUNT_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .xfer_count (xfer_count)
    );

    // Narrow-counter copy sharing the same stimulus, for the wrap check.
    fifo_stream_reader #(.DATA_WIDTH(32), .COUNT_WIDTH(4)) dut_w (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (w_rd2),
        .fifo_dout  (fifo_dout),
        .out_valid  (w_v2),
        .out_ready  (out_ready),
        .out_data   (w_d2),
        .xfer_count (w_cnt2)
    );

    typedef struct {
        logic [31:0] d;
        int          av;
    } ent_t;

    ent_t        pend[$];
    logic [31:0] fifo_q[$];
    logic [31:0] src_q[$];
    logic [31:0] obs_d[$];
    int          obs_c[$];
    int          rd_c[$];
    int          cyc = 0;
    logic [31:0] exp_count = '0;
    bit          chk_on = 1'b0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fifo_push(input logic [31:0] d);
        fifo_q.push_back(d);
        src_q.push_back(d);
        fifo_empty = 1'b0;
    endtask

    task automatic fifo_clear();
        fifo_q.delete();
        src_q.delete();
        fifo_empty = 1'b1;
    endtask

    // One cycle: apply inputs, compare against the model at negedge, advance model and FIFO.
    task automatic tick(input logic r, input logic rdy);
        bit ev;
        bit exp_rd;
        bit deq;
        bit acc;
        rst       = r;
        out_ready = rdy;
        @(negedge clk);
        ev     = (pend.size() > 0) && (pend[0].av <= cyc);
        exp_rd = !rst && !fifo_empty && ((pend.size() - int'(ev && out_ready)) < 2);
        if (chk_on) begin
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("fifo_rd_en", 64'(fifo_rd_en), 64'(exp_rd));
            chk("xfer_count", 64'(xfer_count), 64'(exp_count));
            chk("wrap_valid", 64'(w_v2), 64'(ev));
            chk("wrap_rd_en", 64'(w_rd2), 64'(exp_rd));
            chk("wrap_count", 64'(w_cnt2), 64'(exp_count[3:0]));
            if (ev) begin
                chk("out_data", 64'(out_data), 64'(pend[0].d));
                chk("wrap_data", 64'(w_d2), 64'(pend[0].d));
            end
        end
        acc = fifo_rd_en && !fifo_empty;
        if (acc) rd_c.push_back(cyc);
        if (!rst && out_valid && out_ready) begin
            obs_d.push_back(out_data);
            obs_c.push_back(cyc);
        end
        @(posedge clk);
        deq = ev && out_ready && !rst;
        if (rst) begin
            pend.delete();
            exp_count = '0;
        end else begin
            if (deq) begin
                void'(pend.pop_front());
                exp_count++;
            end
            if (exp_rd && src_q.size() > 0) pend.push_back('{src_q.pop_front(), cyc + 2});
        end
        cyc++;
        #1;
        if (acc && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0);
        fifo_clear();
    endtask

    initial begin
        int          o0;
        int          r0;
        int          c0;
        int          budget;
        int          sent_n;
        logic [31:0] d;
        logic [31:0] sent[$];

        // Reset held with a loaded FIFO: nothing may be read or presented.
        for (int i = 0; i < 5; i++) fifo_push(32'h100 + 32'(i));
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0);
            chk_on = 1'b1;
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_data", 64'(out_data), 64'd0);
            chk("rst_count", 64'(xfer_count), 64'd0);
            chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        end
        fifo_clear();

        // Streaming with continuous ready.
        do_reset();
        for (int i = 1; i <= 8; i++) fifo_push(32'(i));
        o0 = obs_d.size(); r0 = rd_c.size(); c0 = cyc;
        repeat (14) tick(1'b0, 1'b1);
        chk("stream_reads", 64'(rd_c.size() - r0), 64'd8);
        chk("stream_xfers", 64'(obs_d.size() - o0), 64'd8);
        chk("stream_count", 64'(xfer_count), 64'd8);
        if (rd_c.size() > r0) chk("stream_first_rd", 64'(rd_c[r0] - c0), 64'd0);
        if (obs_d.size() >= o0 + 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("stream_data", 64'(obs_d[o0+i]), 64'(i + 1));
                chk("stream_cycle", 64'(obs_c[o0+i] - c0), 64'(i + 2));
            end
        end

        // Backpressure: stalled output holds 0x10, only two reads go out.
        do_reset();
        for (int i = 0; i < 4; i++) fifo_push(32'h10 + 32'(i));
        o0 = obs_d.size(); r0 = rd_c.size(); c0 = cyc;
        for (int k = 1; k <= 6; k++) begin
            tick(1'b0, 1'b0);
            if (k >= 2) begin
                chk("bp_hold_valid", 64'(out_valid), 64'd1);
                chk("bp_hold_data", 64'(out_data), 64'h10);
            end
        end
        chk("bp_reads", 64'(rd_c.size() - r0), 64'd2);
        repeat (6) tick(1'b0, 1'b1);
        chk("bp_xfers", 64'(obs_d.size() - o0), 64'd4);
        if (obs_d.size() >= o0 + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("bp_data", 64'(obs_d[o0+i]), 64'h10 + 64'(i));
                chk("bp_cycle", 64'(obs_c[o0+i] - c0), 64'(6 + i));
            end
        end

        // Random ready and random FIFO writes, scoreboarded against write order.
        do_reset();
        o0 = obs_d.size(); sent_n = 0; budget = 0;
        while ((obs_d.size() - o0) < 100 && budget < 3000) begin
            if (sent_n < 100 && $urandom_range(0, 1) == 1) begin
                d = $urandom;
                fifo_push(d);
                sent.push_back(d);
                sent_n++;
            end
            tick(1'b0, 1'($urandom_range(0, 1)));
            budget++;
        end
        chk("rand_timeout", 64'(budget < 3000), 64'd1);
        repeat (4) tick(1'b0, 1'b1);
        chk("rand_xfers", 64'(obs_d.size() - o0), 64'd100);
        chk("rand_count", 64'(xfer_count), 64'd100);
        if (obs_d.size() >= o0 + 100 && sent.size() == 100) begin
            for (int i = 0; i < 100; i++) chk("rand_order", 64'(obs_d[o0+i]), 64'(sent[i]));
        end

        // Reset one cycle after a read issue; stale flits must vanish.
        do_reset();
        for (int i = 0; i < 5; i++) fifo_push(32'h51 + 32'(i));
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        fifo_clear();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_count", 64'(xfer_count), 64'd0);
        fifo_push(32'hAA);
        o0 = obs_d.size(); budget = 0;
        while (obs_d.size() == o0 && budget < 10) begin
            tick(1'b0, 1'b1);
            budget++;
        end
        chk("mid_rst_timeout", 64'(budget < 10), 64'd1);
        if (obs_d.size() > o0) chk("mid_rst_first", 64'(obs_d[o0]), 64'hAA);

        // Counter wrap on the 4-bit instance.
        do_reset();
        for (int i = 0; i < 17; i++) fifo_push(32'h200 + 32'(i));
        repeat (24) tick(1'b0, 1'b1);
        chk("wrap_count_17", 64'(w_cnt2), 64'd1);
        chk("wide_count_17", 64'(xfer_count), 64'd17);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
